// File: rtl/hub75_rx.sv
// ---------------------------------------------------------------------------
// hub75_rx
// Receive-side HUB75 monitor. Samples the pins driven by the LED-matrix
// driver, rebuilds each latched row of pixels and replays that row as a
// column-ordered valid/ready stream. Also flags latches that arrive after
// the wrong number of shift clocks, and latches that arrive while a row is
// still being drained.
//
// Ports:
//   clk, rst            system clock, synchronous active-low reset
//   hub_r/g/b[1:0]      colour pins, bit0 = upper half, bit1 = lower half
//   hub_row             row address pins
//   hub_clk             shift clock, data taken on its rising edge
//   hub_lat             latch, rising edge commits the shifted row
//   hub_oe              output enable, sampled only
//   out_valid/ready     stream handshake
//   out_row             row address captured at latch
//   out_col             column index of the current beat
//   out_data            pixel {r1,g1,b1,r0,g0,b0}
//   out_last            set on the beat with out_col == COLS-1
//   frame_pulse         one-cycle pulse when a row-0 latch is committed
//   err_len             sticky, latch after a shift count other than COLS
//   err_ovf             sticky, latch arrived while a drain was in progress
// ---------------------------------------------------------------------------
module hub75_rx #(
    parameter int COLS     = 32,
    parameter int ROW_BITS = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [1:0]                hub_r,
    input  logic [1:0]                hub_g,
    input  logic [1:0]                hub_b,
    input  logic [ROW_BITS-1:0]       hub_row,
    input  logic                      hub_clk,
    input  logic                      hub_lat,
    input  logic                      hub_oe,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [ROW_BITS-1:0]       out_row,
    output logic [$clog2(COLS)-1:0]   out_col,
    output logic [5:0]                out_data,
    output logic                      out_last,
    output logic                      frame_pulse,
    output logic                      err_len,
    output logic                      err_ovf
);

    localparam int COL_W = $clog2(COLS);
    localparam int CNT_W = $clog2(COLS + 2);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(COLS);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(COLS + 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    // Input synchronizers. Pixel and row data go through the same depth as
    // the control pins so that a detected clock edge sees matching data.
    // ctl bits are {oe, lat, clk}.
    logic [5:0]          data_s1_q, data_s1_d;
    logic [5:0]          data_s2_q, data_s2_d;
    logic [ROW_BITS-1:0] row_s1_q,  row_s1_d;
    logic [ROW_BITS-1:0] row_s2_q,  row_s2_d;
    logic [2:0]          ctl_s1_q,  ctl_s1_d;
    logic [2:0]          ctl_s2_q,  ctl_s2_d;
    logic [1:0]          ctl_prev_q, ctl_prev_d;

    // Capture and drain state
    logic [COLS-1:0][5:0] shift_q, shift_d;
    logic [COLS-1:0][5:0] hold_q,  hold_d;
    logic [CNT_W-1:0]     shift_cnt_q, shift_cnt_d;
    logic [COL_W-1:0]     col_q, col_d;
    state_t               state_q, state_d;

    // Registered outputs
    logic                 out_valid_q, out_valid_d;
    logic [ROW_BITS-1:0]  out_row_q,   out_row_d;
    logic [5:0]           out_data_q,  out_data_d;
    logic                 out_last_q,  out_last_d;
    logic                 frame_pulse_q, frame_pulse_d;
    logic                 err_len_q,   err_len_d;
    logic                 err_ovf_q,   err_ovf_d;

    logic                 clk_rise;
    logic                 lat_rise;
    logic [COL_W-1:0]     col_inc;

    // OE is synchronized like every other pin but has no effect on capture.
    logic                 oe_unused;
    assign oe_unused = ctl_s2_q[2];

    assign clk_rise = ctl_s2_q[0] & ~ctl_prev_q[0];
    assign lat_rise = ctl_s2_q[1] & ~ctl_prev_q[1];

    // Next-state logic. A shift and a latch seen in the same cycle are
    // handled shift first, so the latch captures the post-shift register
    // and checks the post-shift count.
    always_comb begin
        data_s1_d     = {hub_r[1], hub_g[1], hub_b[1], hub_r[0], hub_g[0], hub_b[0]};
        data_s2_d     = data_s1_q;
        row_s1_d      = hub_row;
        row_s2_d      = row_s1_q;
        ctl_s1_d      = {hub_oe, hub_lat, hub_clk};
        ctl_s2_d      = ctl_s1_q;
        ctl_prev_d    = ctl_s2_q[1:0];

        shift_d       = shift_q;
        hold_d        = hold_q;
        shift_cnt_d   = shift_cnt_q;
        col_d         = col_q;
        state_d       = state_q;
        out_valid_d   = out_valid_q;
        out_row_d     = out_row_q;
        out_data_d    = out_data_q;
        out_last_d    = out_last_q;
        frame_pulse_d = 1'b0;
        err_len_d     = err_len_q;
        err_ovf_d     = err_ovf_q;
        col_inc       = col_q + COL_W'(1);

        if (clk_rise) begin
            shift_d = {shift_q[COLS-2:0], data_s2_q};
            if (shift_cnt_q != CNT_SAT) begin
                shift_cnt_d = shift_cnt_q + CNT_W'(1);
            end
        end

        // Beat acceptance; the next beat is preloaded so outputs stay
        // registered and hold still while the sink stalls.
        if (state_q == ST_DRAIN && out_ready) begin
            if (col_q == COL_LAST) begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
                col_d       = '0;
            end else begin
                col_d       = col_inc;
                out_data_d  = hold_q[col_inc];
                out_last_d  = (col_inc == COL_LAST);
            end
        end

        if (lat_rise) begin
            if (state_q == ST_IDLE) begin
                hold_d        = shift_d;
                out_row_d     = row_s2_q;
                if (shift_cnt_d != CNT_FULL) begin
                    err_len_d = 1'b1;
                end
                frame_pulse_d = (row_s2_q == '0);
                state_d       = ST_DRAIN;
                col_d         = '0;
                out_valid_d   = 1'b1;
                out_data_d    = shift_d[0];
                out_last_d    = 1'b0;
            end else begin
                // Latch during a drain is dropped; the hold buffer keeps
                // the row being replayed.
                err_ovf_d = 1'b1;
            end
            shift_cnt_d = '0;
        end
    end

    // Single state register for the whole block.
    always_ff @(posedge clk) begin
        if (!rst) begin
            data_s1_q     <= '0;
            data_s2_q     <= '0;
            row_s1_q      <= '0;
            row_s2_q      <= '0;
            ctl_s1_q      <= '0;
            ctl_s2_q      <= '0;
            ctl_prev_q    <= '0;
            shift_q       <= '0;
            hold_q        <= '0;
            shift_cnt_q   <= '0;
            col_q         <= '0;
            state_q       <= ST_IDLE;
            out_valid_q   <= 1'b0;
            out_row_q     <= '0;
            out_data_q    <= '0;
            out_last_q    <= 1'b0;
            frame_pulse_q <= 1'b0;
            err_len_q     <= 1'b0;
            err_ovf_q     <= 1'b0;
        end else begin
            data_s1_q     <= data_s1_d;
            data_s2_q     <= data_s2_d;
            row_s1_q      <= row_s1_d;
            row_s2_q      <= row_s2_d;
            ctl_s1_q      <= ctl_s1_d;
            ctl_s2_q      <= ctl_s2_d;
            ctl_prev_q    <= ctl_prev_d;
            shift_q       <= shift_d;
            hold_q        <= hold_d;
            shift_cnt_q   <= shift_cnt_d;
            col_q         <= col_d;
            state_q       <= state_d;
            out_valid_q   <= out_valid_d;
            out_row_q     <= out_row_d;
            out_data_q    <= out_data_d;
            out_last_q    <= out_last_d;
            frame_pulse_q <= frame_pulse_d;
            err_len_q     <= err_len_d;
            err_ovf_q     <= err_ovf_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_row     = out_row_q;
    assign out_col     = col_q;
    assign out_data    = out_data_q;
    assign out_last    = out_last_q;
    assign frame_pulse = frame_pulse_q;
    assign err_len     = err_len_q;
    assign err_ovf     = err_ovf_q;

endmodule

// File: tb/tb_hub75_rx.sv
// ---------------------------------------------------------------------------
// tb_hub75_rx
// Directed bench for hub75_rx with COLS=4. Drives HUB75 pin sequences,
// collects the replayed row beats and compares them with hand-computed
// rows, latencies and flag values.
// ---------------------------------------------------------------------------
module tb_hub75_rx;

    localparam int COLS     = 4;
    localparam int ROW_BITS = 4;

    typedef logic [5:0] pix_arr_t [4];

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic [1:0]          hub_r = '0;
    logic [1:0]          hub_g = '0;
    logic [1:0]          hub_b = '0;
    logic [ROW_BITS-1:0] hub_row = '0;
    logic                hub_clk = 1'b0;
    logic                hub_lat = 1'b0;
    logic                hub_oe = 1'b0;
    logic                out_valid;
    logic                out_ready = 1'b1;
    logic [ROW_BITS-1:0] out_row;
    logic [1:0]          out_col;
    logic [5:0]          out_data;
    logic                out_last;
    logic                frame_pulse;
    logic                err_len;
    logic                err_ovf;

    int       checks   = 0;
    int       failures = 0;
    pix_arr_t exp_data;
    pix_arr_t pix;
    int       first_cyc;
    int       frame_cnt;
    logic     found;

    always #5 clk = ~clk;

    hub75_rx #(
        .COLS(COLS),
        .ROW_BITS(ROW_BITS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .hub_r(hub_r),
        .hub_g(hub_g),
        .hub_b(hub_b),
        .hub_row(hub_row),
        .hub_clk(hub_clk),
        .hub_lat(hub_lat),
        .hub_oe(hub_oe),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_row(out_row),
        .out_col(out_col),
        .out_data(out_data),
        .out_last(out_last),
        .frame_pulse(frame_pulse),
        .err_len(err_len),
        .err_ovf(err_ovf)
    );

    // Counts one comparison and reports it when it does not match.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic drivePixel(input logic [5:0] p);
        hub_r = {p[5], p[2]};
        hub_g = {p[4], p[1]};
        hub_b = {p[3], p[0]};
    endtask

    // One shift clock: two cycles high, two cycles low.
    task automatic shiftPixel(input logic [5:0] p);
        @(posedge clk);
        #1;
        drivePixel(p);
        hub_clk = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        hub_clk = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    // Shifts the first n pixels of the list, in list order.
    task automatic applyStimulus(input pix_arr_t p, input int n);
        for (int i = 0; i < n; i++) begin
            shiftPixel(p[i]);
        end
    endtask

    // Raises hub_lat (optionally together with a shift clock rise) just
    // after a clock edge; the caller lowers it again.
    task automatic startLatch(input logic [ROW_BITS-1:0] row, input logic with_clk,
                              input logic [5:0] p);
        @(posedge clk);
        #1;
        hub_row = row;
        hub_lat = 1'b1;
        if (with_clk) begin
            drivePixel(p);
            hub_clk = 1'b1;
        end
    endtask

    task automatic applyReset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // Collects one row of beats starting right after startLatch. mode 0
    // keeps ready high, mode 1 plays ready = 1,0,0,1,... from the first
    // valid beat. Cycle 0 is the cycle in which the latch was driven.
    task automatic collectRow(input int mode, input logic [ROW_BITS-1:0] exp_row,
                              output int first, output int frames);
        int          k;
        logic        held;
        logic [31:0] saved;
        logic [31:0] cur;
        logic [3:0]  pat;
        pat    = 4'b1001;
        k      = 0;
        held   = 1'b0;
        saved  = '0;
        first  = -1;
        frames = 0;
        for (int cyc = 0; cyc < 40 && k < COLS; cyc++) begin
            @(negedge clk);
            if (frame_pulse) frames++;
            cur = {19'b0, out_last, out_row, out_col, out_data};
            if (held) checkOutput($sformatf("stable_beat%0d", k), cur, saved);
            held = 1'b0;
            if (out_valid) begin
                if (first < 0) first = cyc;
                if (out_ready) begin
                    checkOutput($sformatf("col_beat%0d", k), 32'(out_col), 32'(k));
                    checkOutput($sformatf("data_beat%0d", k), 32'(out_data), 32'(exp_data[k]));
                    checkOutput($sformatf("row_beat%0d", k), 32'(out_row), 32'(exp_row));
                    checkOutput($sformatf("last_beat%0d", k), 32'(out_last),
                                (k == COLS - 1) ? 32'd1 : 32'd0);
                    k++;
                end else begin
                    held  = 1'b1;
                    saved = cur;
                end
            end
            @(posedge clk);
            #1;
            if (cyc == 2) begin
                hub_lat = 1'b0;
                hub_clk = 1'b0;
            end
            if (mode == 1 && first >= 0) out_ready = pat[(cyc + 1 - first) % 4];
            else out_ready = 1'b1;
        end
        checkOutput("beat_count", 32'(k), 32'(COLS));
        repeat (3) @(negedge clk);
        checkOutput("idle_after_row", 32'(out_valid), 32'd0);
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_last", 32'(out_last), 32'd0);
        checkOutput("rst_frame", 32'(frame_pulse), 32'd0);
        checkOutput("rst_err_len", 32'(err_len), 32'd0);
        checkOutput("rst_err_ovf", 32'(err_ovf), 32'd0);
        checkOutput("rst_row", 32'(out_row), 32'd0);
        checkOutput("rst_data", 32'(out_data), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Nominal row, ready held high
        pix      = '{6'h01, 6'h02, 6'h03, 6'h04};
        exp_data = '{6'h04, 6'h03, 6'h02, 6'h01};
        applyStimulus(pix, 4);
        startLatch(4'd5, 1'b0, 6'h00);
        collectRow(0, 4'd5, first_cyc, frame_cnt);
        checkOutput("nominal_latency", 32'(first_cyc), 32'd3);
        checkOutput("nominal_frame", 32'(frame_cnt), 32'd0);
        checkOutput("nominal_err_len", 32'(err_len), 32'd0);
        checkOutput("nominal_err_ovf", 32'(err_ovf), 32'd0);

        // Same row under backpressure
        applyStimulus(pix, 4);
        startLatch(4'd5, 1'b0, 6'h00);
        collectRow(1, 4'd5, first_cyc, frame_cnt);
        checkOutput("bp_err_len", 32'(err_len), 32'd0);

        // Simultaneous clock and latch rise after three shifts
        applyReset();
        pix      = '{6'h21, 6'h22, 6'h23, 6'h00};
        exp_data = '{6'h24, 6'h23, 6'h22, 6'h21};
        applyStimulus(pix, 3);
        startLatch(4'd7, 1'b1, 6'h24);
        collectRow(0, 4'd7, first_cyc, frame_cnt);
        checkOutput("simul_err_len", 32'(err_len), 32'd0);
        checkOutput("simul_latency", 32'(first_cyc), 32'd3);

        // Row 0 latch produces exactly one frame pulse
        pix      = '{6'h31, 6'h32, 6'h33, 6'h34};
        exp_data = '{6'h34, 6'h33, 6'h32, 6'h31};
        applyStimulus(pix, 4);
        startLatch(4'd0, 1'b0, 6'h00);
        collectRow(0, 4'd0, first_cyc, frame_cnt);
        checkOutput("frame_count", 32'(frame_cnt), 32'd1);
        checkOutput("frame_err_len", 32'(err_len), 32'd0);

        // Short row: stale 0x34 stays in column 3
        pix      = '{6'h11, 6'h12, 6'h13, 6'h00};
        exp_data = '{6'h13, 6'h12, 6'h11, 6'h34};
        applyStimulus(pix, 3);
        startLatch(4'd3, 1'b0, 6'h00);
        collectRow(0, 4'd3, first_cyc, frame_cnt);
        checkOutput("short_err_len", 32'(err_len), 32'd1);
        checkOutput("short_err_ovf", 32'(err_ovf), 32'd0);

        // Overflow: second latch during a stalled drain is dropped
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        pix      = '{6'h05, 6'h06, 6'h07, 6'h08};
        applyStimulus(pix, 4);
        startLatch(4'd1, 1'b0, 6'h00);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (out_valid) found = 1'b1;
        end
        checkOutput("ovf_first_valid", 32'(found), 32'd1);
        @(posedge clk);
        #1;
        hub_lat = 1'b0;
        pix = '{6'h2A, 6'h2B, 6'h2C, 6'h2D};
        applyStimulus(pix, 4);
        startLatch(4'd2, 1'b0, 6'h00);
        repeat (4) @(posedge clk);
        #1;
        hub_lat = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("ovf_err_ovf", 32'(err_ovf), 32'd1);
        checkOutput("ovf_valid_held", 32'(out_valid), 32'd1);
        checkOutput("ovf_row_held", 32'(out_row), 32'd1);
        checkOutput("ovf_col_held", 32'(out_col), 32'd0);
        checkOutput("ovf_data_held", 32'(out_data), 32'h08);
        exp_data = '{6'h08, 6'h07, 6'h06, 6'h05};
        collectRow(0, 4'd1, first_cyc, frame_cnt);

        // Reset in the middle of a drain
        pix = '{6'h01, 6'h02, 6'h03, 6'h04};
        applyStimulus(pix, 4);
        startLatch(4'd9, 1'b0, 6'h00);
        repeat (3) @(posedge clk);
        #1;
        hub_lat = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (out_valid && out_col == 2'd2) found = 1'b1;
        end
        checkOutput("mid_reach_beat2", 32'(found), 32'd1);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("mid_valid", 32'(out_valid), 32'd0);
        checkOutput("mid_col", 32'(out_col), 32'd0);
        checkOutput("mid_data", 32'(out_data), 32'd0);
        checkOutput("mid_row", 32'(out_row), 32'd0);
        checkOutput("mid_last", 32'(out_last), 32'd0);
        checkOutput("mid_err_len", 32'(err_len), 32'd0);
        checkOutput("mid_err_ovf", 32'(err_ovf), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("mid_no_more_beats", 32'(out_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
